trail_writer: RTL and testbench
===============================

// Module: trail_writer
// PURPOSE
//  Upstream writer for the 640x480 frame buffer: produces WE/write_address/wr_data for frameRAM's write port.
//  After reset or start_clear, sweeps the whole buffer: background inside, wall colour on the border.
//  On every frame tick, paints the current red and blue bike head positions as trail cells.
//  The display path reads the same buffer as 4-bit colour enums, two pixels per 16-bit word.
// PARAMETERS
//  H_WORDS     320   words per line (640 px / 2)
//  V_LINES     480   lines per frame
//  ADDR_W      19    write address width
//  BG_COLOR    4'h0  background enum
//  WALL_COLOR  4'h8  border enum
//  RED_COLOR   4'h4  red trail enum
//  BLUE_COLOR  4'h6  blue trail enum
// PORTS
//  Clk            in   1       system clock; all logic on rising edge
//  Reset          in   1       asynchronous, active-low reset
//  frame_clk      in   1       ~60 Hz frame tick, asynchronous to Clk
//  start_clear    in   1       1-cycle request to re-clear the buffer (new round)
//  red_x, red_y   in   10      red bike head pixel coordinate
//  blue_x, blue_y in   10      blue bike head pixel coordinate
//  red_alive      in   1       paint red only when 1
//  blue_alive     in   1       paint blue only when 1
//  WE             out  1       frameRAM write enable
//  write_address  out  ADDR_W  frameRAM word address
//  wr_data        out  16      frameRAM word: {4'h0,c,4'h0,c}; even px [3:0], odd px [11:8]
//  busy           out  1       1 while clearing or writing
//  clear_done     out  1       1-cycle pulse when the sweep completes
//  drop_flag      out  1       sticky: a frame tick was discarded during CLEAR; cleared by start_clear
// BEHAVIOUR
//  - Reset values: WE=0, write_address=0, wr_data=0, busy=1, clear_done=0, drop_flag=0, state=CLEAR, cnt=0.
//  - All outputs are registered. Address = y*H_WORDS + x/2, so a trail cell is one word (2x1 px).
//  - frame_clk passes through a 2-FF synchronizer and rising-edge detect -> frame_evt (1 Clk pulse).
//  - States: IDLE, CLEAR, WR_RED, WR_BLUE.
//  - CLEAR: one word per cycle, cnt 0..H_WORDS*V_LINES-1 (153599). WE=1 and write_address=cnt.
//    Colour is WALL_COLOR if line 0, line 479, word 0 or word 319; BG_COLOR otherwise.
//    Pulse clear_done in the cycle after the last word's WE cycle, then go to IDLE.
//  - IDLE: on frame_evt, latch all six position/alive inputs and go to WR_RED.
//    The first WE is in the next cycle.
//  - WR_RED: write RED_COLOR at the latched red position if alive and in range; otherwise WE=0. Go to WR_BLUE.
//  - WR_BLUE: same for blue. Then go to IDLE.
//  - Coordinates with x>=640 or y>=480 are out of range: no write.
//  - frame_evt during CLEAR: dropped and drop_flag set. During WR_*: held in a 1-deep pending bit,
//    served on return to IDLE; a second event while pending is lost.
//  - start_clear wins over frame_evt in the same cycle. From any state: cnt=0, pending=0, drop_flag=0, go to CLEAR.
//    During CLEAR it restarts the sweep from 0.
//  - busy=0 only in IDLE with no pending event. Reset asserted mid-sweep aborts immediately; the sweep restarts after release.
// CONFIGURATION
//  - TRAIL_DOUBLE_EN defined: adds states WR_RED2 and WR_BLUE2, which also write line y+1.
//    Order is red y, red y+1, blue y, blue y+1; y+1 is skipped when y=479.
//  - TRAIL_DOUBLE_EN undefined: exactly two write slots per frame, as above.
// STRUCTURE
//  - tron_pkg: color_e enum (BG/RED/BLUE/WALL), SCREEN_W=640, SCREEN_H=480, H_WORDS, FB_WORDS=153600,
//    and a pack_word(color_e) function.
//  - Sub-module frame_tick_sync: synchronizer plus edge detect for frame_clk.
//  - The address multiply is shift-add (y<<8 + y<<6); no DSP.
// TESTING
//  - Release reset -> 153600 consecutive WE cycles; addr 0 = 16'h0808, addr 321 = 16'h0000,
//    addr 153599 = 16'h0808; clear_done pulses once after them.
//  - Idle, red (100,50), blue (201,60), both alive, frame tick -> WE at addr 16050 with 16'h0404,
//    then addr 19300 with 16'h0606, then busy=0.
//  - red_alive=0, blue (639,479) -> red slot has WE=0, blue writes addr 153599; blue x=640 -> no blue write.
//  - Frame tick mid-sweep -> no trail writes, drop_flag=1; start_clear -> drop_flag=0, sweep restarts at addr 0.
//  - Two ticks 3 cycles apart -> the second is served right after WR_BLUE; start_clear and a tick
//    in the same cycle -> CLEAR only.
//  - With TRAIL_DOUBLE_EN, red (10,479) -> only addr 153285 written for red; red (10,0) -> addrs 5 and 325.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared types and constants for the trail writer and the frame buffer path.
package tron_pkg;

    // Colour enums as stored in the 4-bit pixel fields of the frame buffer
    typedef enum logic [3:0] {
        BG   = 4'h0,
        RED  = 4'h4,
        BLUE = 4'h6,
        WALL = 4'h8
    } color_e;

    // Writer FSM states; the *2 states only exist in the double-height trail build
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        WR_RED   = 3'd2,
        WR_BLUE  = 3'd3,
        WR_RED2  = 3'd4,
        WR_BLUE2 = 3'd5
    } state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int H_WORDS  = 320;
    localparam int FB_WORDS = 153600;

    // Both pixels of a word get the same colour: even px in [3:0], odd px in [11:8]
    function automatic logic [15:0] pack_word(input color_e c);
        return {4'h0, c, 4'h0, c};
    endfunction

endpackage

// File: rtl/trail_writer_frame_tick_sync.sv
// Brings the asynchronous frame tick into the Clk domain and turns each
// rising edge into a single-cycle frame_evt pulse.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_evt
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    // Two-flop synchronizer, one history flop, registered rising-edge pulse
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_3    <= 1'b0;
            frame_evt <= 1'b0;
        end else begin
            sync_1    <= frame_clk;
            sync_2    <= sync_1;
            sync_3    <= sync_2;
            frame_evt <= sync_2 & ~sync_3;
        end
    end

endmodule

// File: rtl/trail_writer.sv
// Frame-buffer writer: sweeps the buffer (walls on the border, background
// inside) after reset or start_clear, then paints the red and blue bike heads
// as one-word trail cells on every frame tick.
// Optional build macro: TRAIL_DOUBLE_EN -- each bike also paints line y+1.
module trail_writer #(
    parameter int          H_WORDS    = tron_pkg::H_WORDS,
    parameter int          V_LINES    = tron_pkg::SCREEN_H,
    parameter int          ADDR_W     = 19,
    parameter logic [3:0]  BG_COLOR   = 4'h0,
    parameter logic [3:0]  WALL_COLOR = 4'h8,
    parameter logic [3:0]  RED_COLOR  = 4'h4,
    parameter logic [3:0]  BLUE_COLOR = 4'h6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              start_clear,
    input  logic [9:0]        red_x,
    input  logic [9:0]        red_y,
    input  logic [9:0]        blue_x,
    input  logic [9:0]        blue_y,
    input  logic              red_alive,
    input  logic              blue_alive,
    output logic              WE,
    output logic [ADDR_W-1:0] write_address,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              clear_done,
    output logic              drop_flag
);

    import tron_pkg::*;

    localparam int FB_LAST = H_WORDS * V_LINES - 1;
    localparam int X_LIMIT = 2 * H_WORDS;

    state_e            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic [8:0]        word_cnt, word_nx;
    logic [9:0]        line_cnt, line_nx;
    logic              pending, pending_nx;
    logic              drop_nx;
    logic              last_word, last_nx;
    logic              we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [15:0]       data_nx;
    logic              busy_nx;
    logic              latch_en;
    logic              frame_evt;
    logic              wall;

    logic [9:0]        lr_x, lr_y, lb_x, lb_y;
    logic              lr_alive, lb_alive;

    logic [9:0]        slot_x;
    logic [10:0]       slot_y;
    logic              slot_alive;
    logic [3:0]        slot_color;
    logic              slot_ok;

    // Word address of a cell; the 320-word line uses shift-add instead of a multiplier
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [10:0] y, input logic [8:0] xw);
        logic [21:0] a;
        if (H_WORDS == 320)
            a = (22'(y) << 8) + (22'(y) << 6) + 22'(xw);
        else
            a = 22'(y) * 22'(H_WORDS) + 22'(xw);
        return ADDR_W'(a);
    endfunction

    frame_tick_sync u_tick_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .frame_evt (frame_evt)
    );

    // Border test for the word the sweep is about to write
    always_comb begin
        wall = (line_cnt == 10'd0) || (line_cnt == 10'(V_LINES - 1)) ||
               (word_cnt == 9'd0)  || (word_cnt == 9'(H_WORDS - 1));
    end

    // Select the latched bike position/colour for the current write slot
    always_comb begin
        slot_x     = lr_x;
        slot_y     = {1'b0, lr_y};
        slot_alive = lr_alive;
        slot_color = RED_COLOR;
        case (state)
            WR_BLUE: begin
                slot_x     = lb_x;
                slot_y     = {1'b0, lb_y};
                slot_alive = lb_alive;
                slot_color = BLUE_COLOR;
            end
`ifdef TRAIL_DOUBLE_EN
            WR_RED2: begin
                slot_y = {1'b0, lr_y} + 11'd1;
            end
            WR_BLUE2: begin
                slot_x     = lb_x;
                slot_y     = {1'b0, lb_y} + 11'd1;
                slot_alive = lb_alive;
                slot_color = BLUE_COLOR;
            end
`endif
            default: ;
        endcase
        slot_ok = slot_alive && ({1'b0, slot_x} < 11'(X_LIMIT)) && (slot_y < 11'(V_LINES));
    end

    // Next-state, event bookkeeping and next output values
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        word_nx    = word_cnt;
        line_nx    = line_cnt;
        pending_nx = pending;
        drop_nx    = drop_flag;
        last_nx    = 1'b0;
        latch_en   = 1'b0;
        we_nx      = 1'b0;
        addr_nx    = write_address;
        data_nx    = wr_data;
        if (start_clear) begin
            // A new round overrides everything, including a simultaneous tick
            state_nx   = CLEAR;
            cnt_nx     = '0;
            word_nx    = '0;
            line_nx    = '0;
            pending_nx = 1'b0;
            drop_nx    = 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    we_nx   = 1'b1;
                    addr_nx = cnt;
                    data_nx = pack_word(wall ? color_e'(WALL_COLOR) : color_e'(BG_COLOR));
                    if (frame_evt)
                        drop_nx = 1'b1;
                    if (cnt == ADDR_W'(FB_LAST)) begin
                        state_nx = IDLE;
                        last_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + ADDR_W'(1);
                        if (word_cnt == 9'(H_WORDS - 1)) begin
                            word_nx = '0;
                            line_nx = line_cnt + 10'd1;
                        end else begin
                            word_nx = word_cnt + 9'd1;
                        end
                    end
                end
                IDLE: begin
                    if (frame_evt || pending) begin
                        latch_en   = 1'b1;
                        pending_nx = 1'b0;
                        state_nx   = WR_RED;
                    end
                end
                default: begin
                    we_nx = slot_ok;
                    if (slot_ok) begin
                        addr_nx = cell_addr(slot_y, slot_x[9:1]);
                        data_nx = pack_word(color_e'(slot_color));
                    end
                    // Only one tick can wait behind the current frame
                    if (frame_evt)
                        pending_nx = 1'b1;
                    case (state)
`ifdef TRAIL_DOUBLE_EN
                        WR_RED:  state_nx = WR_RED2;
                        WR_RED2: state_nx = WR_BLUE;
                        WR_BLUE: state_nx = WR_BLUE2;
`else
                        WR_RED:  state_nx = WR_BLUE;
`endif
                        default: state_nx = IDLE;
                    endcase
                end
            endcase
        end
        busy_nx = !((state_nx == IDLE) && !pending_nx);
    end

    // State, counters and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= CLEAR;
            cnt           <= '0;
            word_cnt      <= '0;
            line_cnt      <= '0;
            pending       <= 1'b0;
            drop_flag     <= 1'b0;
            last_word     <= 1'b0;
            clear_done    <= 1'b0;
            WE            <= 1'b0;
            write_address <= '0;
            wr_data       <= '0;
            busy          <= 1'b1;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            word_cnt      <= word_nx;
            line_cnt      <= line_nx;
            pending       <= pending_nx;
            drop_flag     <= drop_nx;
            last_word     <= last_nx;
            clear_done    <= last_word;
            WE            <= we_nx;
            write_address <= addr_nx;
            wr_data       <= data_nx;
            busy          <= busy_nx;
        end
    end

    // Snapshot of both bikes taken when a frame is accepted
    always_ff @(posedge Clk) begin
        if (latch_en) begin
            lr_x     <= red_x;
            lr_y     <= red_y;
            lr_alive <= red_alive;
            lb_x     <= blue_x;
            lb_y     <= blue_y;
            lb_alive <= blue_alive;
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// Self-checking bench for trail_writer on a reduced 320x64-word buffer.
module tb_trail_writer;

    localparam int H  = 320;
    localparam int V  = 64;
    localparam int FB = H * V;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_clk = 1'b0;
    logic          start_clear = 1'b0;
    logic [9:0]    red_x = '0, red_y = '0, blue_x = '0, blue_y = '0;
    logic          red_alive = 1'b0, blue_alive = 1'b0;
    logic          WE;
    logic [AW-1:0] write_address;
    logic [15:0]   wr_data;
    logic          busy, clear_done, drop_flag;

    trail_writer #(.H_WORDS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .frame_clk     (frame_clk),
        .start_clear   (start_clear),
        .red_x         (red_x),
        .red_y         (red_y),
        .blue_x        (blue_x),
        .blue_y        (blue_y),
        .red_alive     (red_alive),
        .blue_alive    (blue_alive),
        .WE            (WE),
        .write_address (write_address),
        .wr_data       (wr_data),
        .busy          (busy),
        .clear_done    (clear_done),
        .drop_flag     (drop_flag)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] pack(input logic [3:0] c);
        return {4'h0, c, 4'h0, c};
    endfunction

    function automatic logic [15:0] sweep_word(input int idx);
        int line;
        int word;
        line = idx / H;
        word = idx % H;
        if (line == 0 || line == V - 1 || word == 0 || word == H - 1) return pack(4'h8);
        return pack(4'h0);
    endfunction

    logic [AW-1:0] exp_addr_q[$];
    logic [15:0]   exp_data_q[$];

    task automatic add_bike(input int x, input int y, input bit alive, input logic [3:0] c);
        if (alive && x < 2 * H && y < V) begin
            exp_addr_q.push_back(AW'(y * H + x / 2));
            exp_data_q.push_back(pack(c));
`ifdef TRAIL_DOUBLE_EN
            if (y + 1 < V) begin
                exp_addr_q.push_back(AW'((y + 1) * H + x / 2));
                exp_data_q.push_back(pack(c));
            end
`endif
        end
    endtask

    bit          sweep_mode = 0;
    bit          sweep_started = 0;
    bit          done_due = 0;
    int          sweep_idx = 0;
    int          cyc = 0;
    logic [15:0] cap0 = '1, cap321 = '1, caplast = '1;
    int          lg_n = 0;
    logic [AW-1:0] lg_addr[16];
    logic [15:0]   lg_data[16];
    int            lg_cyc[16];

    // Per-cycle compare of the write port against the model
    always @(posedge clk) begin : cmp
        bit due;
        #1;
        cyc++;
        if (rst_n) begin
            due = done_due;
            done_due = 0;
            check("clear_done", int'(clear_done), int'(due));
            if (sweep_mode) begin
                if (WE) begin
                    check("sweep_addr", int'(write_address), sweep_idx);
                    check("sweep_data", int'(wr_data), int'(sweep_word(sweep_idx)));
                    if (sweep_idx == 0)      cap0 = wr_data;
                    if (sweep_idx == 321)    cap321 = wr_data;
                    if (sweep_idx == FB - 1) caplast = wr_data;
                    sweep_started = 1;
                    sweep_idx++;
                    if (sweep_idx == FB) begin
                        sweep_mode = 0;
                        done_due = 1;
                    end
                end else if (sweep_started) begin
                    check("sweep_continuous_we", int'(WE), 1);
                end
            end else if (WE) begin
                if (lg_n < 16) begin
                    lg_addr[lg_n] = write_address;
                    lg_data[lg_n] = wr_data;
                    lg_cyc[lg_n]  = cyc;
                end
                lg_n++;
                if (exp_addr_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_we: addr %0d data %0h, required no write", write_address, wr_data);
                end else begin
                    check("trail_addr", int'(write_address), int'(exp_addr_q.pop_front()));
                    check("trail_data", int'(wr_data), int'(exp_data_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic restart_model();
        sweep_mode = 1;
        sweep_idx = 0;
        sweep_started = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic wait_sweep();
        int n;
        n = 0;
        while (sweep_mode && n < FB + 200) begin
            @(negedge clk);
            n++;
        end
        check("sweep_finished_in_time", int'(sweep_mode), 0);
    endtask

    task automatic run_frame(input int rx, input int ry, input bit ra,
                             input int bx, input int by, input bit ba,
                             input int ticks, input int gap);
        @(negedge clk);
        red_x = rx[9:0];  red_y = ry[9:0];  red_alive = ra;
        blue_x = bx[9:0]; blue_y = by[9:0]; blue_alive = ba;
        lg_n = 0;
        for (int t = 0; t < ticks; t++) begin
            add_bike(rx, ry, ra, 4'h4);
            add_bike(bx, by, ba, 4'h6);
        end
        for (int t = 0; t < ticks; t++) begin
            frame_clk = 1'b1;
            @(negedge clk);
            frame_clk = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("frame_writes_all_seen", exp_addr_q.size(), 0);
        check("busy_after_frame", int'(busy), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int gap_cycles;
        int blue_i;

        repeat (3) @(negedge clk);
        check("reset_WE", int'(WE), 0);
        check("reset_addr", int'(write_address), 0);
        check("reset_data", int'(wr_data), 0);
        check("reset_busy", int'(busy), 1);
        check("reset_clear_done", int'(clear_done), 0);
        check("reset_drop_flag", int'(drop_flag), 0);

        // Sweep after reset, with a tick dropped mid-way
        restart_model();
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("busy_in_sweep", int'(busy), 1);
        frame_clk = 1'b1;
        repeat (4) @(negedge clk);
        frame_clk = 1'b0;
        repeat (20) @(negedge clk);
        check("drop_flag_set", int'(drop_flag), 1);
        check("busy_after_drop", int'(busy), 1);

        // start_clear restarts the sweep at 0 and clears drop_flag
        restart_model();
        start_clear = 1'b1;
        @(negedge clk);
        start_clear = 1'b0;
        check("drop_flag_cleared", int'(drop_flag), 0);
        wait_sweep();
        repeat (3) @(negedge clk);
        check("cap_addr0", int'(cap0), 16'h0808);
        check("cap_addr321", int'(cap321), 16'h0000);
        check("cap_addr_last", int'(caplast), 16'h0808);
        check("busy_idle", int'(busy), 0);
        check("drop_flag_idle", int'(drop_flag), 0);

        // Both bikes alive
        run_frame(100, 50, 1, 201, 60, 1, 1, 2);
`ifdef TRAIL_DOUBLE_EN
        blue_i = 2;
        check("pair_count", lg_n, 4);
`else
        blue_i = 1;
        check("pair_count", lg_n, 2);
        check("pair_slots_adjacent", lg_cyc[1] - lg_cyc[0], 1);
`endif
        check("red_addr_lit", int'(lg_addr[0]), 16050);
        check("red_data_lit", int'(lg_data[0]), 16'h0404);
        check("blue_addr_lit", int'(lg_addr[blue_i]), 19300);
        check("blue_data_lit", int'(lg_data[blue_i]), 16'h0606);

        // Dead red, blue at the last cell
        run_frame(5, 5, 0, 639, V - 1, 1, 1, 2);
        check("last_cell_count", lg_n, 1);
        check("last_cell_addr", int'(lg_addr[0]), FB - 1);

        // Blue just off the right edge
        run_frame(5, 5, 0, 640, 10, 1, 1, 2);
        check("offscreen_count", lg_n, 0);

`ifdef TRAIL_DOUBLE_EN
        run_frame(10, V - 1, 1, 0, 0, 0, 1, 2);
        check("dbl_bottom_count", lg_n, 1);
        check("dbl_bottom_addr", int'(lg_addr[0]), (V - 1) * H + 5);
        run_frame(10, 0, 1, 0, 0, 0, 1, 2);
        check("dbl_top_count", lg_n, 2);
        check("dbl_top_addr0", int'(lg_addr[0]), 5);
        check("dbl_top_addr1", int'(lg_addr[1]), 325);
`endif

        // Two ticks close together: the second is held and served
        for (int sp = 2; sp <= 3; sp++) begin
            run_frame(300, 20, 1, 301, 21, 1, 2, sp);
`ifdef TRAIL_DOUBLE_EN
            check("two_tick_count", lg_n, 8);
            gap_cycles = lg_cyc[4] - lg_cyc[3];
`else
            check("two_tick_count", lg_n, 4);
            gap_cycles = lg_cyc[2] - lg_cyc[1];
`endif
            check("pending_served_promptly", int'(gap_cycles <= 3), 1);
        end

        // Randomised frames, some off-screen or dead
        for (int i = 0; i < 30; i++) begin
            run_frame($urandom_range(0, 700), $urandom_range(0, V + 6), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 700), $urandom_range(0, V + 6), 1'($urandom_range(0, 1)), 1, 2);
        end

        // start_clear held across a tick: CLEAR only, nothing dropped
        restart_model();
        frame_clk = 1'b1;
        start_clear = 1'b1;
        repeat (6) @(negedge clk);
        start_clear = 1'b0;
        repeat (300) @(negedge clk);
        frame_clk = 1'b0;
        check("clear_vs_tick_drop_flag", int'(drop_flag), 0);
        check("clear_vs_tick_busy", int'(busy), 1);
        check("clear_vs_tick_no_trail", int'(sweep_idx > 0), 1);

        // Reset in the middle of a sweep aborts it; sweep restarts afterwards
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        restart_model();
        repeat (2) @(negedge clk);
        check("midreset_WE", int'(WE), 0);
        check("midreset_addr", int'(write_address), 0);
        check("midreset_busy", int'(busy), 1);
        rst_n = 1'b1;
        wait_sweep();
        repeat (3) @(negedge clk);
        check("final_busy", int'(busy), 0);
        check("final_queue_empty", exp_addr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
